// File: rtl/strided_buffer_writer_pkg.sv
// Shared definitions for the strided line-buffer writer and reader.
package strided_buffer_writer_pkg;

    localparam int unsigned N_BUF_X    = 10;
    localparam int unsigned B_BUF_ADDR = 9;
    localparam int unsigned B_SHAPE    = 25;
    localparam int unsigned B_COORD    = 9;
    localparam int unsigned DATA_WIDTH = 64;

    // Packed shape layout: [8:0]=w, [17:9]=h, [24:18]=n_wrap_c
    localparam int unsigned W_LSB  = 0;
    localparam int unsigned H_LSB  = 9;
    localparam int unsigned C_LSB  = 18;
    localparam int unsigned W_BITS = H_LSB - W_LSB;
    localparam int unsigned H_BITS = C_LSB - H_LSB;
    localparam int unsigned C_BITS = B_SHAPE - C_LSB;

    // Footprint width: one extra bit so a completely full buffer is representable
    localparam int unsigned B_FP      = B_BUF_ADDR + 1;
    localparam int unsigned BUF_DEPTH = 1 << B_BUF_ADDR;
    localparam int unsigned B_BANK    = $clog2(N_BUF_X);
    localparam int unsigned B_GRP     = B_COORD + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    function automatic logic [W_BITS-1:0] shape_w(input logic [B_SHAPE-1:0] s);
        return s[W_LSB +: W_BITS];
    endfunction

    function automatic logic [H_BITS-1:0] shape_h(input logic [B_SHAPE-1:0] s);
        return s[H_LSB +: H_BITS];
    endfunction

    function automatic logic [C_BITS-1:0] shape_c(input logic [B_SHAPE-1:0] s);
        return s[C_LSB +: C_BITS];
    endfunction

    // Number of column groups per bank: ceil(w / N_BUF_X)
    function automatic logic [B_GRP-1:0] col_groups(input logic [W_BITS-1:0] w);
        return (B_GRP'(w) + B_GRP'(N_BUF_X - 1)) / B_GRP'(N_BUF_X);
    endfunction

endpackage

// File: rtl/strided_buffer_addr_gen.sv
// Channel/row/column walker producing bank select and in-bank address.
module strided_buffer_addr_gen
    import strided_buffer_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    input  logic                  adv_i,
    input  logic [W_BITS-1:0]     w_i,
    input  logic [H_BITS-1:0]     h_i,
    input  logic [C_BITS-1:0]     nc_i,
    input  logic [B_BUF_ADDR-1:0] base_i,
    output logic [B_BUF_ADDR-1:0] addr_c_o,
    output logic [B_BANK-1:0]     bank_c_o,
    output logic                  last_c_o
);

    logic [C_BITS-1:0]  c_q,    c_d;
    logic [B_COORD-1:0] y_q,    y_d;
    logic [B_COORD-1:0] x_q,    x_d;
    logic [B_BANK-1:0]  xrem_q, xrem_d;
    logic [B_COORD-1:0] xquo_q, xquo_d;

    logic c_end_c, y_end_c, x_end_c, xrem_end_c;

    assign c_end_c    = (c_q == nc_i - C_BITS'(1));
    assign y_end_c    = (y_q == B_COORD'(h_i - H_BITS'(1)));
    assign x_end_c    = (x_q == B_COORD'(w_i - W_BITS'(1)));
    assign xrem_end_c = (xrem_q == B_BANK'(N_BUF_X - 1));

    // Counter advance: channel fastest, then row, then column (bank, group)
    always_comb begin
        c_d    = c_q;
        y_d    = y_q;
        x_d    = x_q;
        xrem_d = xrem_q;
        xquo_d = xquo_q;
        if (clr_i) begin
            c_d    = '0;
            y_d    = '0;
            x_d    = '0;
            xrem_d = '0;
            xquo_d = '0;
        end else if (adv_i) begin
            if (!c_end_c) begin
                c_d = c_q + C_BITS'(1);
            end else begin
                c_d = '0;
                if (!y_end_c) begin
                    y_d = y_q + B_COORD'(1);
                end else begin
                    y_d = '0;
                    x_d = x_q + B_COORD'(1);
                    if (xrem_end_c) begin
                        xrem_d = '0;
                        xquo_d = xquo_q + B_COORD'(1);
                    end else begin
                        xrem_d = xrem_q + B_BANK'(1);
                    end
                end
            end
        end
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            c_q    <= '0;
            y_q    <= '0;
            x_q    <= '0;
            xrem_q <= '0;
            xquo_q <= '0;
        end else begin
            c_q    <= c_d;
            y_q    <= y_d;
            x_q    <= x_d;
            xrem_q <= xrem_d;
            xquo_q <= xquo_d;
        end
    end

    // Modular arithmetic in bank-address width equals the truncated full-width result
    logic [B_BUF_ADDR-1:0] nc_a, h_a, y_a, c_a, xquo_a;

    assign nc_a   = B_BUF_ADDR'(nc_i);
    assign h_a    = B_BUF_ADDR'(h_i);
    assign y_a    = B_BUF_ADDR'(y_q);
    assign c_a    = B_BUF_ADDR'(c_q);
    assign xquo_a = B_BUF_ADDR'(xquo_q);

    assign addr_c_o = base_i + nc_a * (y_a + h_a * xquo_a) + c_a;
    assign bank_c_o = xrem_q;
    assign last_c_o = c_end_c && y_end_c && x_end_c;

endmodule

// File: rtl/strided_buffer_writer.sv
// Fill stage of the strided line buffer: scatters a channel-fastest stream over
// column banks and manages circular-buffer space per map.
module strided_buffer_writer
    import strided_buffer_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [B_SHAPE-1:0]    ftm_shape,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  rd_done,
    output logic [N_BUF_X-1:0]    wr_en,
    output logic [B_BUF_ADDR-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  map_done,
    output logic [B_BUF_ADDR-1:0] wr_base,
    output logic                  err
);

    localparam int unsigned B_PROD = C_BITS + H_BITS + B_GRP;

    wr_state_e             state_q,    state_d;
    logic [B_SHAPE-1:0]    shape_q,    shape_d;
    logic [B_FP-1:0]       fp_q,       fp_d;
    logic [B_FP-1:0]       used_q,     used_d;
    logic [B_BUF_ADDR-1:0] wr_base_q,  wr_base_d;
    logic                  tready_q,   tready_d;
    logic                  busy_q,     busy_d;
    logic                  map_done_q, map_done_d;
    logic                  err_q,      err_d;
    logic [N_BUF_X-1:0]    wr_en_q,    wr_en_d;
    logic [B_BUF_ADDR-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;

    logic                  hs_c, clr_c, grant_c, rel_c, last_c, fits_c, fp_big_c;
    logic [B_PROD-1:0]     fp_full_c;
    logic [B_FP-1:0]       fp_c;
    logic [B_BUF_ADDR-1:0] addr_c;
    logic [B_BANK-1:0]     bank_c;

    assign hs_c = s_axis_tvalid & tready_q;

    // Footprint of the latched shape, checked against the whole buffer before truncation
    assign fp_full_c = B_PROD'(shape_c(shape_q)) * B_PROD'(shape_h(shape_q))
                     * B_PROD'(col_groups(shape_w(shape_q)));
    assign fp_big_c  = (fp_full_c > B_PROD'(BUF_DEPTH));
    assign fp_c      = fp_big_c ? '0 : B_FP'(fp_full_c);
    assign fits_c    = ((B_FP + 1)'(used_q) + (B_FP + 1)'(fp_c)) <= (B_FP + 1)'(BUF_DEPTH);

    strided_buffer_addr_gen u_addr_gen (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (clr_c),
        .adv_i    (hs_c),
        .w_i      (shape_w(shape_q)),
        .h_i      (shape_h(shape_q)),
        .nc_i     (shape_c(shape_q)),
        .base_i   (wr_base_q),
        .addr_c_o (addr_c),
        .bank_c_o (bank_c),
        .last_c_o (last_c)
    );

    // Next-state: map sequencing, write path, space accounting and error flag
    always_comb begin
        state_d    = state_q;
        shape_d    = shape_q;
        fp_d       = fp_q;
        used_d     = used_q;
        wr_base_d  = wr_base_q;
        map_done_d = 1'b0;
        err_d      = err_q;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        clr_c      = 1'b0;
        grant_c    = 1'b0;
        rel_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shape_d = ftm_shape;
                    clr_c   = 1'b1;
                    state_d = ST_RESV;
                end
            end
            ST_RESV: begin
                fp_d = fp_c;
                if (fp_big_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (fits_c) begin
                    grant_c = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (hs_c) begin
                    wr_en_d   = N_BUF_X'(1) << bank_c;
                    wr_addr_d = addr_c;
                    wr_data_d = s_axis_tdata;
                    if (s_axis_tlast != last_c) begin
                        err_d = 1'b1;
                    end
                    if (last_c) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                map_done_d = 1'b1;
                wr_base_d  = wr_base_q + B_BUF_ADDR'(fp_q);
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Release uses the footprint of the latched shape; an empty buffer cannot be released
        if (rd_done) begin
            if (used_q == '0) begin
                err_d = 1'b1;
            end else begin
                rel_c = 1'b1;
            end
        end
        if (grant_c) begin
            used_d = used_d + fp_c;
        end
        if (rel_c) begin
            used_d = used_d - fp_c;
        end

        tready_d = (state_d == ST_WRITE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            shape_q    <= '0;
            fp_q       <= '0;
            used_q     <= '0;
            wr_base_q  <= '0;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
            map_done_q <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            shape_q    <= shape_d;
            fp_q       <= fp_d;
            used_q     <= used_d;
            wr_base_q  <= wr_base_d;
            tready_q   <= tready_d;
            busy_q     <= busy_d;
            map_done_q <= map_done_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign busy          = busy_q;
    assign map_done      = map_done_q;
    assign wr_base       = wr_base_q;
    assign err           = err_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_strided_buffer_writer.sv
// Bench for strided_buffer_writer: random data and valid gaps, reference write list
// derived from the column/row/channel layout rules.
module tb_strided_buffer_writer;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [24:0] ftm_shape;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        rd_done;
    logic [9:0]  wr_en;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic        busy;
    logic        map_done;
    logic [8:0]  wr_base;
    logic        err;

    strided_buffer_writer dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .ftm_shape     (ftm_shape),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .rd_done       (rd_done),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .map_done      (map_done),
        .wr_base       (wr_base),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          bank;
        int          addr;
        logic [63:0] data;
    } wr_t;

    int   errors = 0;
    int   checks = 0;
    wr_t  expq[$];
    wr_t  mon_e;
    int   exp_base = 0;
    bit   exp_err = 1'b0;
    bit   prev_wr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fp_of(input int w, input int h, input int c);
        return c * h * ((w + 9) / 10);
    endfunction

    // Write monitor: every write must match the oldest outstanding accepted word
    always @(negedge clk) begin
        if (wr_en !== 10'd0) begin
            chk("write_has_handshake", 64'(expq.size() > 0), 64'(1));
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                chk("wr_en", 64'(wr_en), 64'(1) << mon_e.bank);
                chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                chk("wr_data", wr_data, mon_e.data);
            end
        end
        if (map_done === 1'b1) begin
            chk("map_done_after_last_write", 64'(prev_wr), 64'(1));
            chk("map_done_all_written", 64'(expq.size()), 64'(0));
        end
        prev_wr = (wr_en !== 10'd0);
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
        chk({tag, "_tready"}, 64'(tready), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_map_done"}, 64'(map_done), 64'(0));
        chk({tag, "_wr_base"}, 64'(wr_base), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rstn = 1'b0; start = 1'b0; tvalid = 1'b0; tlast = 1'b0; rd_done = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_wr_addr", 64'(wr_addr), 64'(0));
        chk("reset_wr_data", wr_data, 64'(0));
        #1 rstn = 1'b1;
        exp_base = 0;
        exp_err  = 1'b0;
        expq.delete();
    endtask

    task automatic start_map(input int w, input int h, input int c);
        @(negedge clk); #1;
        ftm_shape = {7'(c), 9'(h), 9'(w)};
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_rd_done();
        @(negedge clk); #1 rd_done = 1'b1;
        @(negedge clk); #1 rd_done = 1'b0;
    endtask

    // Streams one map; bad_k puts a stray tlast on that word, abort_k asserts reset there
    task automatic send_map(input int w, input int h, input int c, input int gap_pct,
                            input int bad_k, input int abort_k);
        int  lay_bank[$];
        int  lay_addr[$];
        int  n;
        int  k;
        int  cyc;
        bit  hs;
        wr_t e;
        for (int x = 0; x < w; x++)
            for (int y = 0; y < h; y++)
                for (int cc = 0; cc < c; cc++) begin
                    lay_bank.push_back(x % 10);
                    lay_addr.push_back((exp_base + c * (y + h * (x / 10)) + cc) % 512);
                end
        n = lay_bank.size();
        k = 0;
        cyc = 0;
        while (k < n) begin
            @(negedge clk); #1;
            if (k == abort_k) begin
                rstn   = 1'b0;
                tvalid = 1'b1;
                tdata  = {$urandom, $urandom};
                tlast  = 1'b0;
                return;
            end
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                tdata  = {$urandom, $urandom};
            end else begin
                tvalid = 1'b1;
                tdata  = {$urandom, $urandom};
                tlast  = (k == n - 1) || (k == bad_k);
            end
            hs = tvalid && (tready === 1'b1);
            if (hs) begin
                e.bank = lay_bank[k];
                e.addr = lay_addr[k];
                e.data = tdata;
                expq.push_back(e);
                if (k == bad_k && k != n - 1) exp_err = 1'b1;
                k++;
            end
            cyc++;
            if (cyc > 20 * n + 200) begin
                chk("send_timeout_words", 64'(k), 64'(n));
                tvalid = 1'b0;
                return;
            end
        end
        @(negedge clk); #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic finish_map(input int w, input int h, input int c);
        int i;
        i = 0;
        while (map_done !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("map_done_seen", 64'(map_done), 64'(1));
        exp_base = (exp_base + fp_of(w, h, c)) % 512;
        chk("wr_base", 64'(wr_base), 64'(exp_base));
        chk("err", 64'(err), 64'(exp_err));
        chk("busy_after_done", 64'(busy), 64'(0));
    endtask

    task automatic run_map(input int w, input int h, input int c, input int gap_pct,
                           input int bad_k);
        start_map(w, h, c);
        send_map(w, h, c, gap_pct, bad_k, -1);
        finish_map(w, h, c);
    endtask

    task automatic check_hold(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({tag, "_tready"}, 64'(tready), 64'(0));
            chk({tag, "_busy"}, 64'(busy), 64'(1));
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; ftm_shape = '0; tdata = '0;
        tvalid = 1'b0; tlast = 1'b0; rd_done = 1'b0;

        // Reset state, then a 12x2x1 map with continuous valid: fp=4
        do_reset();
        run_map(12, 2, 1, 0, -1);

        // Same map with random valid gaps
        run_map(12, 2, 1, 40, -1);

        // Ten 48-word maps fill 480; map 11 waits for a release, base wraps 480 -> 16
        do_reset();
        for (int m = 0; m < 10; m++) run_map(10, 16, 3, (m % 3 == 0) ? 25 : 0, -1);
        chk("base_after_ten", 64'(wr_base), 64'(480));
        start_map(10, 16, 3);
        check_hold("map11_hold", 20);
        pulse_rd_done();
        send_map(10, 16, 3, 0, -1, -1);
        finish_map(10, 16, 3);
        chk("base_wrapped", 64'(wr_base), 64'(16));
        start_map(10, 16, 3);
        check_hold("map12_hold", 10);
        pulse_rd_done();
        send_map(10, 16, 3, 10, -1, -1);
        finish_map(10, 16, 3);

        // Release coinciding with the grant at used=464, fp=48: net zero
        do_reset();
        run_map(1, 16, 29, 0, -1);
        @(negedge clk); #1;
        ftm_shape = {7'(3), 9'(16), 9'(10)};
        start = 1'b1;
        @(negedge clk); #1;
        start   = 1'b0;
        rd_done = 1'b1;
        @(negedge clk); #1;
        rd_done = 1'b0;
        chk("grant_with_rd_done_tready", 64'(tready), 64'(1));
        send_map(10, 16, 3, 0, -1, -1);
        finish_map(10, 16, 3);
        run_map(10, 16, 3, 0, -1);
        start_map(10, 16, 3);
        check_hold("full_hold", 10);

        // Stray tlast on word 5: err set, map still completes after 24 words
        do_reset();
        run_map(12, 2, 1, 0, 5);

        // Reset during word 10 discards the map
        start_map(12, 2, 1);
        send_map(12, 2, 1, 0, -1, 10);
        @(negedge clk);
        check_idle_outputs("midmap_reset");
        #1;
        rstn   = 1'b1;
        tvalid = 1'b0;
        chk("midmap_no_pending", 64'(expq.size()), 64'(0));
        exp_base = 0;
        exp_err  = 1'b0;
        expq.delete();
        run_map(12, 2, 1, 0, -1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
